ahb_mem_arbiter: RTL and testbench
==================================

AHB_MEM_ARBITER -- requirements
Module: ahb_mem_arbiter

Interface
REQ-001 Parameters: none; all buses SHALL be fixed AHB-Lite widths.
REQ-002 HCLK  in  1  single clock; all state on rising edge.
REQ-003 HRESETn  in  1  reset, asynchronous, active-low.
REQ-004 S0_HADDR / S1_HADDR  in  32  address from master port 0 (CPU) / port 1 (DMA).
REQ-005 S0_HTRANS / S1_HTRANS  in  2  transfer type per port; bit1=1 is NONSEQ/SEQ.
REQ-006 S0_HWRITE / S1_HWRITE  in  1  write flag per port.
REQ-007 S0_HSIZE / S1_HSIZE  in  3  transfer size per port.
REQ-008 S0_HWDATA / S1_HWDATA  in  32  write data per port.
REQ-009 S0_HREADYOUT / S1_HREADYOUT  out  1  per-port ready back to master.
REQ-010 S0_HRDATA / S1_HRDATA  out  32  read data per port.
REQ-011 M_HSEL, M_HADDR[31:0], M_HTRANS[1:0], M_HWRITE, M_HSIZE[2:0], M_HWDATA[31:0]  out  to memory slave.
REQ-012 M_HREADY  out  1  HREADY to slave; equals M_HREADYOUT.
REQ-013 M_HREADYOUT  in  1  slave ready; M_HRDATA  in  32  slave read data.

Function
REQ-014 Port n SHALL request when Sn_HTRANS[1]=1 while Sn_HREADYOUT=1, or when pending_n=1.
REQ-015 Grant SHALL be decided only in cycles with M_HREADYOUT=1; otherwise M_ address/control SHALL hold.
REQ-016 Granted port's control SHALL drive M_ outputs combinationally: from its pending buffer if pending_n=1, else live inputs; M_HSEL=1.
REQ-017 No request: M_HSEL=0, M_HTRANS=IDLE(00), other M_ control 0.
REQ-018 Requesting, non-granted port SHALL store HADDR/HTRANS/HWRITE/HSIZE into its pending buffer and set pending_n at the clock edge.
REQ-019 pending_n SHALL clear at the edge its buffered address phase is accepted (granted with M_HREADYOUT=1).
REQ-020 Data-phase FSM states: IDLE, DATA0, DATA1; on edge with M_HREADYOUT=1 go to DATAn if port n granted, else IDLE; hold otherwise.
REQ-021 M_HWDATA SHALL be Sn_HWDATA of the data-phase owner; 0 in IDLE.
REQ-022 Sn_HRDATA SHALL equal M_HRDATA for both ports.
REQ-023 Sn_HREADYOUT = M_HREADYOUT in DATAn; else 0 if pending_n=1; else 1.
REQ-024 Uncontended transfer SHALL incur zero added cycles; contended loser waits at least one cycle per winning transfer.
REQ-025 Arbitration per transfer; SEQ bursts are not locked and may interleave.
REQ-026 Both ports request same cycle: winner per REQ-033/034; loser buffered per REQ-018.

Reset
REQ-027 On HRESETn=0 (any time, mid-transfer included): FSM=IDLE, pending_0=pending_1=0, buffers cleared, RR pointer=last-granted S1.
REQ-028 Reset outputs: Sn_HREADYOUT=1, M_HSEL=0, M_HTRANS=00, M_HWDATA=0.
REQ-029 In-flight and pending transfers SHALL be dropped, not replayed, after reset.

Configuration
REQ-030 Macro ARB_ROUND_ROBIN_EN selects policy.
REQ-031 Policy applies only when both ports request in the same grant cycle.
REQ-032 Single requester SHALL always be granted regardless of policy.
REQ-033 Undefined: fixed priority, S0 always wins.
REQ-034 Defined: port not granted last wins; pointer updates on every accepted address phase.

Verification
REQ-035 S0 single write 0x20000010 data 0xCAFEF00D, S1 idle -> M_ mirrors S0 same cycle, S0_HREADYOUT never 0, later S0 read returns 0xCAFEF00D.
REQ-036 S0 and S1 NONSEQ same cycle (S0 write 0x100, S1 write 0x200), macro off -> 0x100 on M_HADDR first, S1_HREADYOUT=0 one cycle, 0x200 next cycle, both data written.
REQ-037 Both ports issue 4 back-to-back word reads, macro on -> M_HADDR alternates S0,S1,S0,S1...; macro off -> all S0 first.
REQ-038 Slave holds M_HREADYOUT=0 two cycles during S1 data phase while S0 requests -> S0 buffered, M_ control stable, S0 granted on first ready cycle.
REQ-039 HRESETn asserted while S1 pending and S0 in DATA0 -> next cycle both HREADYOUT=1, M_HTRANS=00, no write to memory.
REQ-040 S1 byte write 0xAB to 0x203 contended by S0 -> after grant M_HSIZE=000, M_HADDR=0x203, M_HWDATA carries S1_HWDATA in DATA1.

Source files
------------

// File: rtl/ahb_mem_arbiter.sv
// ahb_mem_arbiter: two AHB-Lite masters (S0 CPU, S1 DMA) sharing one memory slave.
// Define ARB_ROUND_ROBIN_EN for round-robin arbitration; default is fixed S0 priority.
module ahb_mem_arbiter (
  input  logic        HCLK,
  input  logic        HRESETn,
  input  logic [31:0] S0_HADDR,
  input  logic [1:0]  S0_HTRANS,
  input  logic        S0_HWRITE,
  input  logic [2:0]  S0_HSIZE,
  input  logic [31:0] S0_HWDATA,
  output logic        S0_HREADYOUT,
  output logic [31:0] S0_HRDATA,
  input  logic [31:0] S1_HADDR,
  input  logic [1:0]  S1_HTRANS,
  input  logic        S1_HWRITE,
  input  logic [2:0]  S1_HSIZE,
  input  logic [31:0] S1_HWDATA,
  output logic        S1_HREADYOUT,
  output logic [31:0] S1_HRDATA,
  output logic        M_HSEL,
  output logic [31:0] M_HADDR,
  output logic [1:0]  M_HTRANS,
  output logic        M_HWRITE,
  output logic [2:0]  M_HSIZE,
  output logic [31:0] M_HWDATA,
  output logic        M_HREADY,
  input  logic        M_HREADYOUT,
  input  logic [31:0] M_HRDATA
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DATA0 = 2'd1,
    DATA1 = 2'd2
  } dstate_t;

  typedef struct packed {
    logic [31:0] addr;
    logic [1:0]  trans;
    logic        write;
    logic [2:0]  size;
  } aph_t;

  dstate_t state_q, state_d;

  aph_t aph0, aph1, buf0_q, buf1_q, sel;
  logic pend0_q, pend1_q;
  logic new0, new1, req0, req1;
  logic gnt_vld, gnt_id;
  logic acc, acc0, acc1;
  logic hold_q, hold_id_q;
`ifdef ARB_ROUND_ROBIN_EN
  logic last_q;
`endif

  assign aph0 = {S0_HADDR, S0_HTRANS, S0_HWRITE, S0_HSIZE};
  assign aph1 = {S1_HADDR, S1_HTRANS, S1_HWRITE, S1_HSIZE};

  assign S0_HREADYOUT = (state_q == DATA0) ? M_HREADYOUT : ~pend0_q;
  assign S1_HREADYOUT = (state_q == DATA1) ? M_HREADYOUT : ~pend1_q;

  assign new0 = S0_HTRANS[1] & S0_HREADYOUT & ~pend0_q;
  assign new1 = S1_HTRANS[1] & S1_HREADYOUT & ~pend1_q;
  assign req0 = new0 | pend0_q;
  assign req1 = new1 | pend1_q;

  // A grant shown during a wait state is frozen until the slave is ready.
  always_comb begin
    gnt_vld = 1'b0;
    gnt_id  = 1'b0;
    if (hold_q) begin
      gnt_vld = 1'b1;
      gnt_id  = hold_id_q;
    end else if (req0 && req1) begin
      gnt_vld = 1'b1;
`ifdef ARB_ROUND_ROBIN_EN
      gnt_id  = ~last_q;
`else
      gnt_id  = 1'b0;
`endif
    end else if (req0 || req1) begin
      gnt_vld = 1'b1;
      gnt_id  = req1;
    end
  end

  assign acc  = gnt_vld & M_HREADYOUT;
  assign acc0 = acc & ~gnt_id;
  assign acc1 = acc & gnt_id;

  always_comb begin
    sel = '0;
    if (gnt_vld) begin
      if (gnt_id)
        sel = pend1_q ? buf1_q : aph1;
      else
        sel = pend0_q ? buf0_q : aph0;
    end
  end

  assign M_HSEL   = gnt_vld;
  assign M_HADDR  = sel.addr;
  assign M_HTRANS = sel.trans;
  assign M_HWRITE = sel.write;
  assign M_HSIZE  = sel.size;
  assign M_HREADY = M_HREADYOUT;

  assign S0_HRDATA = M_HRDATA;
  assign S1_HRDATA = M_HRDATA;

  always_comb begin
    unique case (state_q)
      DATA0:   M_HWDATA = S0_HWDATA;
      DATA1:   M_HWDATA = S1_HWDATA;
      default: M_HWDATA = 32'h0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    if (M_HREADYOUT) begin
      if (!gnt_vld)
        state_d = IDLE;
      else if (gnt_id)
        state_d = DATA1;
      else
        state_d = DATA0;
    end
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn)
      state_q <= IDLE;
    else
      state_q <= state_d;
  end

  // The master has moved on once it saw ready, so any unaccepted phase is captured.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      pend0_q   <= 1'b0;
      pend1_q   <= 1'b0;
      buf0_q    <= '0;
      buf1_q    <= '0;
      hold_q    <= 1'b0;
      hold_id_q <= 1'b0;
    end else begin
      if (new0 && !acc0) begin
        pend0_q <= 1'b1;
        buf0_q  <= aph0;
      end else if (acc0) begin
        pend0_q <= 1'b0;
      end
      if (new1 && !acc1) begin
        pend1_q <= 1'b1;
        buf1_q  <= aph1;
      end else if (acc1) begin
        pend1_q <= 1'b0;
      end
      hold_q    <= gnt_vld & ~M_HREADYOUT;
      hold_id_q <= gnt_id;
    end
  end

`ifdef ARB_ROUND_ROBIN_EN
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn)
      last_q <= 1'b1;
    else if (acc)
      last_q <= gnt_id;
  end
`endif

endmodule

// File: tb/tb_ahb_mem_arbiter.sv
// tb_ahb_mem_arbiter: directed bench with a memory slave model and an
// address/data-phase scoreboard for ahb_mem_arbiter.
module tb_ahb_mem_arbiter;

  logic        HCLK = 1'b0;
  logic        HRESETn;
  logic [31:0] S0_HADDR, S1_HADDR;
  logic [1:0]  S0_HTRANS, S1_HTRANS;
  logic        S0_HWRITE, S1_HWRITE;
  logic [2:0]  S0_HSIZE, S1_HSIZE;
  logic [31:0] S0_HWDATA, S1_HWDATA;
  logic        S0_HREADYOUT, S1_HREADYOUT;
  logic [31:0] S0_HRDATA, S1_HRDATA;
  logic        M_HSEL;
  logic [31:0] M_HADDR;
  logic [1:0]  M_HTRANS;
  logic        M_HWRITE;
  logic [2:0]  M_HSIZE;
  logic [31:0] M_HWDATA;
  logic        M_HREADY;
  logic        M_HREADYOUT;
  logic [31:0] M_HRDATA;

  always #5 HCLK = ~HCLK;

  ahb_mem_arbiter dut (
    .HCLK(HCLK), .HRESETn(HRESETn),
    .S0_HADDR(S0_HADDR), .S0_HTRANS(S0_HTRANS),
    .S0_HWRITE(S0_HWRITE), .S0_HSIZE(S0_HSIZE),
    .S0_HWDATA(S0_HWDATA), .S0_HREADYOUT(S0_HREADYOUT),
    .S0_HRDATA(S0_HRDATA),
    .S1_HADDR(S1_HADDR), .S1_HTRANS(S1_HTRANS),
    .S1_HWRITE(S1_HWRITE), .S1_HSIZE(S1_HSIZE),
    .S1_HWDATA(S1_HWDATA), .S1_HREADYOUT(S1_HREADYOUT),
    .S1_HRDATA(S1_HRDATA),
    .M_HSEL(M_HSEL), .M_HADDR(M_HADDR), .M_HTRANS(M_HTRANS),
    .M_HWRITE(M_HWRITE), .M_HSIZE(M_HSIZE), .M_HWDATA(M_HWDATA),
    .M_HREADY(M_HREADY), .M_HREADYOUT(M_HREADYOUT),
    .M_HRDATA(M_HRDATA)
  );

  // Memory slave model; contents start as 0x5A000000 | byte address.
  logic [31:0] mem [0:1023];
  logic        mem_init = 1'b0;
  logic        dp_vld, dp_wr;
  logic [31:0] dp_addr;
  logic [2:0]  dp_size;
  logic [3:0]  be;

  always_comb begin
    case (dp_size)
      3'd0:    be = 4'b0001 << dp_addr[1:0];
      3'd1:    be = dp_addr[1] ? 4'b1100 : 4'b0011;
      default: be = 4'b1111;
    endcase
  end

  always @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      dp_vld <= 1'b0;
      if (!mem_init) begin
        for (int i = 0; i < 1024; i++)
          mem[i] <= 32'h5A000000 | 32'(i << 2);
        mem_init <= 1'b1;
      end
    end else if (M_HREADYOUT) begin
      if (dp_vld && dp_wr)
        for (int b = 0; b < 4; b++)
          if (be[b])
            mem[dp_addr[11:2]][8*b +: 8] <= M_HWDATA[8*b +: 8];
      dp_vld  <= M_HSEL && M_HTRANS[1];
      dp_addr <= M_HADDR;
      dp_wr   <= M_HWRITE;
      dp_size <= M_HSIZE;
    end
  end

  assign M_HRDATA = (dp_vld && !dp_wr) ? mem[dp_addr[11:2]] : 32'h0;

  typedef struct {
    logic [31:0] addr;
    logic        wr;
    logic [2:0]  size;
    logic [31:0] data;
    logic        port;
  } xfer_t;

  xfer_t sb[$];
  xfer_t cur;
  bit    cur_vld;
  int    tests = 0;
  int    fails = 0;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic push(input logic [31:0] a, input logic w,
                      input logic [2:0] sz, input logic [31:0] d,
                      input logic p);
    xfer_t x;
    x.addr = a; x.wr = w; x.size = sz; x.data = d; x.port = p;
    sb.push_back(x);
  endtask

  // Monitor: pops on each accepted address phase, checks the matching data phase.
  initial begin
    cur_vld = 1'b0;
    forever begin
      @(negedge HCLK);
      if (!HRESETn) begin
        cur_vld = 1'b0;
      end else if (M_HREADYOUT) begin
        if (cur_vld) begin
          if (cur.wr)
            chk("wdata", M_HWDATA, cur.data);
          else
            chk("rdata", cur.port ? S1_HRDATA : S0_HRDATA, cur.data);
          chk("dp_ready", {31'b0, cur.port ? S1_HREADYOUT : S0_HREADYOUT}, 1);
          cur_vld = 1'b0;
        end
        if (M_HSEL && M_HTRANS[1]) begin
          if (sb.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL unexpected_aph: got addr %h expected none", M_HADDR);
          end else begin
            cur = sb.pop_front();
            chk("aph_addr", M_HADDR, cur.addr);
            chk("aph_write", {31'b0, M_HWRITE}, {31'b0, cur.wr});
            chk("aph_size", {29'b0, M_HSIZE}, {29'b0, cur.size});
            cur_vld = 1'b1;
          end
        end
      end
    end
  end

  task automatic cyc();
    @(posedge HCLK);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic idle();
    S0_HTRANS = 2'b00;
    S1_HTRANS = 2'b00;
    S0_HWRITE = 1'b0;
    S1_HWRITE = 1'b0;
  endtask

  task automatic m0(input logic [31:0] a, input logic w, input logic [2:0] sz);
    S0_HADDR = a; S0_HTRANS = 2'b10; S0_HWRITE = w; S0_HSIZE = sz;
  endtask

  task automatic m1(input logic [31:0] a, input logic w, input logic [2:0] sz);
    S1_HADDR = a; S1_HTRANS = 2'b10; S1_HWRITE = w; S1_HSIZE = sz;
  endtask

  task automatic do_reset();
    HRESETn = 1'b0;
    cyc();
    cyc();
    HRESETn = 1'b1;
  endtask

  task automatic chk_reset_outs(input string tag);
    chk({tag, "_rdy0"}, {31'b0, S0_HREADYOUT}, 1);
    chk({tag, "_rdy1"}, {31'b0, S1_HREADYOUT}, 1);
    chk({tag, "_hsel"}, {31'b0, M_HSEL}, 0);
    chk({tag, "_htrans"}, {30'b0, M_HTRANS}, 0);
    chk({tag, "_hwdata"}, M_HWDATA, 0);
  endtask

  initial begin
    int i0, i1, n;
    HRESETn = 1'b0;
    M_HREADYOUT = 1'b1;
    S0_HADDR = '0; S1_HADDR = '0;
    S0_HSIZE = 3'd2; S1_HSIZE = 3'd2;
    S0_HWDATA = '0; S1_HWDATA = '0;
    idle();
    cyc();
    cyc();
    settle();
    chk_reset_outs("reset");
    cyc();
    HRESETn = 1'b1;

    // Uncontended S0 write then read back.
    cyc();
    m0(32'h20000010, 1'b1, 3'd2);
    push(32'h20000010, 1'b1, 3'd2, 32'hCAFEF00D, 1'b0);
    settle();
    chk("s0w_haddr", M_HADDR, 32'h20000010);
    chk("s0w_hsel", {31'b0, M_HSEL}, 1);
    chk("s0w_rdy0", {31'b0, S0_HREADYOUT}, 1);
    cyc();
    idle();
    S0_HWDATA = 32'hCAFEF00D;
    settle();
    chk("s0w_rdy0_dp", {31'b0, S0_HREADYOUT}, 1);
    cyc();
    m0(32'h20000010, 1'b0, 3'd2);
    push(32'h20000010, 1'b0, 3'd2, 32'hCAFEF00D, 1'b0);
    settle();
    chk("s0r_rdy0", {31'b0, S0_HREADYOUT}, 1);
    cyc();
    idle();
    cyc();

    // Same-cycle contention, S0 wins after reset in either policy.
    do_reset();
    cyc();
    m0(32'h100, 1'b1, 3'd2);
    m1(32'h200, 1'b1, 3'd2);
    push(32'h100, 1'b1, 3'd2, 32'h11110100, 1'b0);
    push(32'h200, 1'b1, 3'd2, 32'h22220200, 1'b1);
    settle();
    chk("con_first", M_HADDR, 32'h100);
    chk("con_rdy1_a", {31'b0, S1_HREADYOUT}, 1);
    cyc();
    idle();
    S0_HWDATA = 32'h11110100;
    S1_HWDATA = 32'h22220200;
    settle();
    chk("con_second", M_HADDR, 32'h200);
    chk("con_rdy1_wait", {31'b0, S1_HREADYOUT}, 0);
    cyc();
    settle();
    chk("con_rdy1_done", {31'b0, S1_HREADYOUT}, 1);
    chk("con_hsel_idle", {31'b0, M_HSEL}, 0);
    cyc();
    m0(32'h100, 1'b0, 3'd2);
    push(32'h100, 1'b0, 3'd2, 32'h11110100, 1'b0);
    cyc();
    m0(32'h200, 1'b0, 3'd2);
    push(32'h200, 1'b0, 3'd2, 32'h22220200, 1'b0);
    cyc();
    idle();
    cyc();

    // Both ports issue four back-to-back word reads.
    do_reset();
`ifdef ARB_ROUND_ROBIN_EN
    for (int k = 0; k < 4; k++) begin
      push(32'h300 + 32'(4 * k), 1'b0, 3'd2, 32'h5A000300 + 32'(4 * k), 1'b0);
      push(32'h400 + 32'(4 * k), 1'b0, 3'd2, 32'h5A000400 + 32'(4 * k), 1'b1);
    end
`else
    for (int k = 0; k < 4; k++)
      push(32'h300 + 32'(4 * k), 1'b0, 3'd2, 32'h5A000300 + 32'(4 * k), 1'b0);
    for (int k = 0; k < 4; k++)
      push(32'h400 + 32'(4 * k), 1'b0, 3'd2, 32'h5A000400 + 32'(4 * k), 1'b1);
`endif
    i0 = 0;
    i1 = 0;
    n = 0;
    while ((i0 < 4 || i1 < 4) && n < 40) begin
      cyc();
      n++;
      if (i0 < 4) m0(32'h300 + 32'(4 * i0), 1'b0, 3'd2);
      else S0_HTRANS = 2'b00;
      if (i1 < 4) m1(32'h400 + 32'(4 * i1), 1'b0, 3'd2);
      else S1_HTRANS = 2'b00;
      settle();
      if (i0 < 4 && S0_HREADYOUT) i0++;
      if (i1 < 4 && S1_HREADYOUT) i1++;
    end
    chk("burst_done", {31'b0, (i0 == 4 && i1 == 4)}, 1);
    cyc();
    idle();
    repeat (4) cyc();

    // Slave wait states during S1 data phase while S0 requests.
    do_reset();
    cyc();
    m1(32'h500, 1'b0, 3'd2);
    push(32'h500, 1'b0, 3'd2, 32'h5A000500, 1'b1);
    settle();
    chk("ws_s1_addr", M_HADDR, 32'h500);
    cyc();
    idle();
    M_HREADYOUT = 1'b0;
    m0(32'h600, 1'b1, 3'd2);
    push(32'h600, 1'b1, 3'd2, 32'h66660600, 1'b0);
    settle();
    chk("ws_addr_a", M_HADDR, 32'h600);
    chk("ws_rdy1_a", {31'b0, S1_HREADYOUT}, 0);
    cyc();
    idle();
    S0_HWDATA = 32'h66660600;
    settle();
    chk("ws_addr_hold", M_HADDR, 32'h600);
    chk("ws_write_hold", {31'b0, M_HWRITE}, 1);
    chk("ws_rdy0_pend", {31'b0, S0_HREADYOUT}, 0);
    cyc();
    M_HREADYOUT = 1'b1;
    settle();
    chk("ws_grant_addr", M_HADDR, 32'h600);
    chk("ws_rdy1_done", {31'b0, S1_HREADYOUT}, 1);
    cyc();
    settle();
    chk("ws_rdy0_dp", {31'b0, S0_HREADYOUT}, 1);
    cyc();
    cyc();

    // Reset with S0 in its data phase and S1 pending.
    do_reset();
    cyc();
    m0(32'h700, 1'b1, 3'd2);
    m1(32'h704, 1'b1, 3'd2);
    push(32'h700, 1'b1, 3'd2, 32'h77770700, 1'b0);
    settle();
    chk("rst_mid_first", M_HADDR, 32'h700);
    cyc();
    idle();
    S0_HWDATA = 32'h77770700;
    S1_HWDATA = 32'h77770704;
    settle();
    chk("rst_mid_pend1", {31'b0, S1_HREADYOUT}, 0);
    HRESETn = 1'b0;
    #1;
    chk_reset_outs("rst_mid");
    cyc();
    HRESETn = 1'b1;
    settle();
    chk("rst_no_replay", {31'b0, M_HSEL}, 0);
    cyc();
    settle();
    chk("rst_no_replay2", {31'b0, M_HSEL}, 0);
    chk("rst_mem700", mem[10'h1C0], 32'h5A000700);
    chk("rst_mem704", mem[10'h1C1], 32'h5A000704);

    // Contended S1 byte write.
    do_reset();
    cyc();
    m0(32'h800, 1'b1, 3'd2);
    m1(32'h203, 1'b1, 3'd0);
    push(32'h800, 1'b1, 3'd2, 32'h88880800, 1'b0);
    push(32'h203, 1'b1, 3'd0, 32'hAB000000, 1'b1);
    settle();
    chk("byte_first", M_HADDR, 32'h800);
    cyc();
    idle();
    S0_HWDATA = 32'h88880800;
    S1_HWDATA = 32'hAB000000;
    settle();
    chk("byte_addr", M_HADDR, 32'h203);
    chk("byte_size", {29'b0, M_HSIZE}, 0);
    cyc();
    settle();
    chk("byte_hwdata", M_HWDATA, 32'hAB000000);
    cyc();
    m1(32'h200, 1'b0, 3'd2);
    push(32'h200, 1'b0, 3'd2, 32'hAB220200, 1'b1);
    cyc();
    idle();
    cyc();
    cyc();

    chk("sb_empty", sb.size(), 0);
    chk("no_open_dp", {31'b0, cur_vld}, 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
